pmem_write_buffer: RTL and testbench



---
 rtl/pmem_write_buffer.sv | 150 +++++++++++++++
 tb/tb_pmem_write_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer: single-entry write-back buffer between the L1 arbiter and
// physical memory. A dirty line from the arbiter is absorbed in one cycle and
// drained to memory later. Read misses are served ahead of a pending drain.
//
// Optional feature macro: WB_READ_BYPASS_EN
//   defined   - a read that hits the buffered line is served from the buffer
//   undefined - a read hit first drains the line, then reads it from memory
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   arb_address/read/write/wdata  request from the arbiter (held until arb_resp)
//   arb_rdata, arb_resp           read line and one-cycle completion pulse
//   pmem_address/read/write/wdata request to memory (held until pmem_resp)
//   pmem_rdata, pmem_resp         memory read line and completion pulse
module pmem_write_buffer #(
  parameter int unsigned LINE_OFFSET = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  arb_address,
  input  logic         arb_read,
  input  logic         arb_write,
  input  logic [127:0] arb_wdata,
  output logic [127:0] arb_rdata,
  output logic         arb_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {StIdle, StReadMem, StDrain, StAck} state_e;

  state_e         state_q, state_d;
  logic           wb_valid;
  logic [15:0]    wb_addr;
  logic [127:0]   wb_data;

  logic hit;
  logic wb_load, wb_clear;
  logic enter_read, enter_drain;
  logic mem_rd_done, bypass_rd;

  assign hit = wb_valid && (arb_address[15:LINE_OFFSET] == wb_addr[15:LINE_OFFSET]);

  always_comb begin
    state_d     = state_q;
    wb_load     = 1'b0;
    wb_clear    = 1'b0;
    enter_read  = 1'b0;
    enter_drain = 1'b0;
    mem_rd_done = 1'b0;
    bypass_rd   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Read wins if both requests are (illegally) raised together.
        if (arb_read) begin
          if (hit) begin
`ifdef WB_READ_BYPASS_EN
            bypass_rd = 1'b1;
            state_d   = StAck;
`else
            // Drain first so memory holds the newest copy, then re-evaluate.
            enter_drain = 1'b1;
            state_d     = StDrain;
`endif
          end else begin
            enter_read = 1'b1;
            state_d    = StReadMem;
          end
        end else if (arb_write) begin
          if (!wb_valid || hit) begin
            wb_load = 1'b1;
            state_d = StAck;
          end else begin
            // Write is accepted on return to idle once the old line is out.
            enter_drain = 1'b1;
            state_d     = StDrain;
          end
        end else if (wb_valid) begin
          enter_drain = 1'b1;
          state_d     = StDrain;
        end
      end
      StReadMem: begin
        if (pmem_resp) begin
          mem_rd_done = 1'b1;
          state_d     = StAck;
        end
      end
      StDrain: begin
        if (pmem_resp) begin
          wb_clear = 1'b1;
          state_d  = StIdle;
        end
      end
      StAck: begin
        // Requests are ignored here; the arbiter may drop one cycle late.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      arb_rdata    <= '0;
      arb_resp     <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state_q    <= state_d;
      // Strobes are registered from the next state so they align with it.
      arb_resp   <= (state_d == StAck);
      pmem_read  <= (state_d == StReadMem);
      pmem_write <= (state_d == StDrain);

      if (wb_load) begin
        wb_valid <= 1'b1;
        wb_addr  <= arb_address;
        wb_data  <= arb_wdata;
      end else if (wb_clear) begin
        wb_valid <= 1'b0;
      end

      // Address/data captured once on entry, stable for the whole transaction.
      if (enter_read) begin
        pmem_address <= arb_address;
      end else if (enter_drain) begin
        pmem_address <= wb_addr;
        pmem_wdata   <= wb_data;
      end

      if (mem_rd_done) begin
        arb_rdata <= pmem_rdata;
      end else if (bypass_rd) begin
        arb_rdata <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Testbench for pmem_write_buffer: directed scenarios plus randomized traffic.
// Expected read data comes from an arbiter-level memory image (the last line
// written per line address); a separate monitor checks each arb_resp.
module tb_pmem_write_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  arb_address;
  logic         arb_read, arb_write;
  logic [127:0] arb_wdata, arb_rdata;
  logic         arb_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  pmem_write_buffer #(.LINE_OFFSET(4)) dut (
    .clk(clk), .reset(reset),
    .arb_address(arb_address), .arb_read(arb_read), .arb_write(arb_write),
    .arb_wdata(arb_wdata), .arb_rdata(arb_rdata), .arb_resp(arb_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { bit rd; logic [127:0] data; } exp_t;
  typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } mem_op_t;

  exp_t         exp_q[$];
  mem_op_t      mem_log[$];
  logic [127:0] phys_mem[int];
  logic [127:0] ref_mem[int];
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           mem_en = 1'b1;
  int           fixed_lat = -1;

  function automatic void chk(string nm, logic [127:0] got, logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endfunction

  function automatic logic [127:0] init_line(int ln);
    logic [31:0] w;
    w = (32'(ln) * 32'h9e3779b9) ^ 32'h5a5a0000;
    return {w, ~w, w + 32'd1, w ^ 32'hffff};
  endfunction

  function automatic logic [127:0] ref_get(logic [15:0] a);
    int ln = int'(a >> 4);
    return ref_mem.exists(ln) ? ref_mem[ln] : init_line(ln);
  endfunction

  // Memory responder: fixed or random latency, logs every completed access.
  initial begin : responder
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [15:0] op_addr;
    logic [127:0] op_data;
    bit          op_wr;
    mem_op_t     m;
    int          ln;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_en) begin
        busy = 1'b0;
      end else begin
        pmem_resp = 1'b0;
        if (reset) begin
          busy = 1'b0;
        end else begin
          if (!busy && (pmem_read || pmem_write)) begin
            busy    = 1'b1;
            cnt     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            op_addr = pmem_address;
            op_data = pmem_wdata;
            op_wr   = pmem_write;
          end
          if (busy) begin
            if (cnt == 0) begin
              chk("pmem_addr_stable", 128'(pmem_address), 128'(op_addr));
              ln = int'(op_addr >> 4);
              if (op_wr) begin
                chk("pmem_wdata_stable", pmem_wdata, op_data);
                phys_mem[ln] = op_data;
              end else begin
                pmem_rdata = phys_mem.exists(ln) ? phys_mem[ln] : init_line(ln);
              end
              m.wr = op_wr; m.addr = op_addr; m.data = op_wr ? op_data : pmem_rdata;
              mem_log.push_back(m);
              pmem_resp = 1'b1;
              busy = 1'b0;
            end else begin
              cnt--;
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every arb_resp.
  initial begin : monitor
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rd_wr_exclusive", 128'(pmem_read && pmem_write), 128'(0));
        if (arb_resp) begin
          chk("resp_single_cycle", 128'(prev), 128'(0));
          chk("resp_outstanding", 128'(exp_q.size() > 0), 128'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.rd) chk("arb_rdata", arb_rdata, e.data);
          end
        end
      end
      prev = arb_resp;
    end
  end

  // Issue one request, wait (bounded) for arb_resp, then drop it. Returns the
  // cycle index of arb_resp relative to the cycle the request was presented.
  task automatic arb_txn(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [127:0] d, output int cyc);
    exp_t e;
    bit   got = 1'b0;
    e.rd = rd;
    e.data = rd ? ref_get(a) : '0;
    if (!rd && wr) ref_mem[int'(a >> 4)] = d;
    exp_q.push_back(e);
    arb_address = a; arb_read = rd; arb_write = wr; arb_wdata = d;
    cyc = -1;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (arb_resp) got = 1'b1;
    end
    chk("txn_completes", 128'(got), 128'(1));
    @(posedge clk);
    #1;
    arb_read = 1'b0; arb_write = 1'b0;
  endtask

  task automatic settle();
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    arb_read = 1'b0; arb_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ref_mem = phys_mem;
    exp_q.delete();
  endtask

  task automatic chk_log(string nm, int idx, bit wr, logic [15:0] a, logic [127:0] d);
    chk({nm, "_present"}, 128'(mem_log.size() > idx), 128'(1));
    if (mem_log.size() > idx) begin
      chk({nm, "_op"}, 128'(mem_log[idx].wr), 128'(wr));
      chk({nm, "_line"}, 128'(mem_log[idx].addr >> 4), 128'(a >> 4));
      if (wr) chk({nm, "_data"}, mem_log[idx].data, d);
    end
  endtask

  localparam logic [127:0] DA = 128'h0123_4567_89ab_cdef_aaaa_0000_1111_2222;
  localparam logic [127:0] DB = 128'hbbbb_cccc_dddd_eeee_ffff_0101_2323_4545;
  localparam logic [127:0] DC = 128'hc0c0_c1c1_c2c2_c3c3_c4c4_c5c5_c6c6_c7c7;
  localparam logic [127:0] DD = 128'hd00d_d11d_d22d_d33d_d44d_d55d_d66d_d77d;
  localparam logic [127:0] DE = 128'hee00_ee11_ee22_ee33_ee44_ee55_ee66_ee77;

  initial begin : stim
    int  cyc, l0;
    bit  saw;
    bit  rd, wr;
    logic [15:0] a;
    logic [127:0] d;

    reset = 1'b1;
    arb_address = '0; arb_read = 1'b0; arb_write = 1'b0; arb_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arb_resp", 128'(arb_resp), 128'(0));
    chk("rst_arb_rdata", arb_rdata, 128'(0));
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_pmem_address", 128'(pmem_address), 128'(0));
    chk("rst_pmem_wdata", pmem_wdata, 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write, then drain.
    l0 = mem_log.size();
    arb_txn(1'b0, 1'b1, 16'h1230, DA, cyc);
    chk("wr_latency", 128'(cyc), 128'(1));
    settle();
    chk("wr_drain_count", 128'(mem_log.size()), 128'(l0 + 1));
    chk_log("wr_drain", l0, 1'b1, 16'h1230, DA);
    chk("wr_drain_cleared", 128'(dut.wb_valid), 128'(0));

    // Coalescing write to the same line.
    do_reset();
    l0 = mem_log.size();
    arb_txn(1'b0, 1'b1, 16'h1230, DA, cyc);
    arb_txn(1'b0, 1'b1, 16'h1238, DB, cyc);
    chk("coalesce_latency", 128'(cyc), 128'(1));
    settle();
    chk("coalesce_count", 128'(mem_log.size()), 128'(l0 + 1));
    chk_log("coalesce", l0, 1'b1, 16'h1238, DB);

    // Read miss overtakes the pending drain.
    do_reset();
    l0 = mem_log.size();
    arb_txn(1'b0, 1'b1, 16'h2000, DC, cyc);
    fixed_lat = 5;
    arb_txn(1'b1, 1'b0, 16'h4000, '0, cyc);
    fixed_lat = -1;
    chk("rdmiss_latency", 128'(cyc), 128'(7));
    settle();
    chk("rdmiss_count", 128'(mem_log.size()), 128'(l0 + 2));
    chk_log("rdmiss_read", l0, 1'b0, 16'h4000, '0);
    chk_log("rdmiss_drain", l0 + 1, 1'b1, 16'h2000, DC);

    // Read hit on the buffered line.
    do_reset();
    l0 = mem_log.size();
    arb_txn(1'b0, 1'b1, 16'h2000, DC, cyc);
    arb_txn(1'b1, 1'b0, 16'h2004, '0, cyc);
`ifdef WB_READ_BYPASS_EN
    chk("bypass_latency", 128'(cyc), 128'(1));
    chk("bypass_no_mem", 128'(mem_log.size()), 128'(l0));
    settle();
    chk_log("bypass_drain", l0, 1'b1, 16'h2000, DC);
`else
    settle();
    chk("rdhit_count", 128'(mem_log.size()), 128'(l0 + 2));
    chk_log("rdhit_drain", l0, 1'b1, 16'h2000, DC);
    chk_log("rdhit_read", l0 + 1, 1'b0, 16'h2000, '0);
`endif

    // Write miss with a full buffer: drain first, then accept.
    do_reset();
    l0 = mem_log.size();
    arb_txn(1'b0, 1'b1, 16'h2000, DC, cyc);
    fixed_lat = 2;
    arb_txn(1'b0, 1'b1, 16'h3000, DD, cyc);
    fixed_lat = -1;
    chk("wrmiss_latency", 128'(cyc), 128'(5));
    chk_log("wrmiss_old", l0, 1'b1, 16'h2000, DC);
    settle();
    chk_log("wrmiss_new", l0 + 1, 1'b1, 16'h3000, DD);

    // Reset in the middle of a drain.
    do_reset();
    arb_txn(1'b0, 1'b1, 16'h5000, DE, cyc);
    mem_en = 1'b0;
    pmem_resp = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk);
      if (pmem_write) saw = 1'b1;
    end
    chk("rstdrain_started", 128'(saw), 128'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_mem = phys_mem;
    exp_q.delete();
    @(negedge clk);
    chk("rstdrain_pmem_write", 128'(pmem_write), 128'(0));
    chk("rstdrain_wb_valid", 128'(dut.wb_valid), 128'(0));
    @(posedge clk);
    #1;
    pmem_resp = 1'b1;
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (arb_resp) saw = 1'b1;
    end
    chk("rstdrain_stray_resp", 128'(saw), 128'(0));
    @(posedge clk);
    #1;
    mem_en = 1'b1;
    // The discarded line must not be visible: memory still has the old value.
    arb_txn(1'b1, 1'b0, 16'h5004, '0, cyc);

    // Randomized traffic over a few lines so hits, misses and drains mix.
    for (int n = 0; n < 200; n++) begin
      a  = 16'((16'h100 + 16'($urandom_range(0, 3))) << 4) | 16'($urandom_range(0, 15));
      d  = {$urandom, $urandom, $urandom, $urandom};
      rd = ($urandom_range(0, 1) == 0);
      wr = !rd || ($urandom_range(0, 9) == 0);
      arb_txn(rd, wr, a, d, cyc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
      #0;
    end
    settle();
    // Every buffered line must end up in memory.
    for (int ln = 16'h100; ln < 16'h104; ln++) begin
      chk("final_mem_image",
          phys_mem.exists(ln) ? phys_mem[ln] : init_line(ln),
          ref_mem.exists(ln) ? ref_mem[ln] : init_line(ln));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
